multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/regfile.sv | 19 +
 rtl/multicycle_cpu.sv | 128 ++++++++++++
 tb/tb_multicycle_cpu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: state, opcode, funct and ALU-op encodings shared by multicycle_cpu
package cpu_pkg;
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NONE} alu_op_t;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_HALT  = 6'h3F;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   // ALU_NONE marks instructions that never reach WB (branches, jumps, NOPs)
   function automatic alu_op_t decode_alu(input logic [5:0] op, input logic [5:0] fn);
      if (op == OP_RTYPE)
         return fn == FN_ADD ? ALU_ADD : fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND :
                fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : ALU_NONE;
      return (op == OP_ADDI || op == OP_LW || op == OP_SW) ? ALU_ADD : ALU_NONE;
   endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 32 x WIDTH register file, two async read ports, one write port, r0 hardwired to zero
module regfile #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             we,
   input  logic [4:0]       ra1,
   input  logic [4:0]       ra2,
   input  logic [4:0]       wa,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2
);
   logic [WIDTH-1:0] regs [32];
   always_ff @(posedge clk)
      if (we && wa != 5'd0) regs[wa] <= wd;
   assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
   assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: MIPS-subset multicycle core with loadable instruction memory.
// Define BNE_EN to add bne (opcode 0x05); otherwise 0x05 executes as a NOP.
module multicycle_cpu #(
   parameter int WIDTH      = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             initialize,
   input  logic [31:0]      instruction_initialize_data,
   input  logic [WIDTH-1:0] instruction_initialize_address,
   output logic [WIDTH-1:0] pc_out,
   output logic [2:0]       state_out,
   output logic             halted,
   output logic [15:0]      retired
);
   import cpu_pkg::*;
   localparam int IA = $clog2(IMEM_DEPTH);
   localparam int DA = $clog2(DMEM_DEPTH);
   state_t state;
   logic [31:0] imem [IMEM_DEPTH];
   logic [WIDTH-1:0] dmem [DMEM_DEPTH];
   logic [31:0] ir;
   logic [WIDTH-1:0] pc, a, b, simm, alu_out, mdr;
   logic [WIDTH-1:0] rd1, rd2, bsrc, alu_y, jump_pc, wb_data;
   logic [5:0] op, fn;
   logic [4:0] wb_addr;
   alu_op_t alu_op;
   logic branch, rf_we, unused_bits;
   assign op = ir[31:26];
   assign fn = ir[5:0];
   assign alu_op = decode_alu(op, fn);
   assign bsrc = op == OP_RTYPE ? b : simm;
   assign alu_y = alu_op == ALU_SUB ? a - bsrc :
                  alu_op == ALU_AND ? a & bsrc :
                  alu_op == ALU_OR  ? a | bsrc :
                  alu_op == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(bsrc)} :
                  a + bsrc;
`ifdef BNE_EN
   assign branch = (op == OP_BEQ && a == b) || (op == OP_BNE && a != b);
`else
   assign branch = op == OP_BEQ && a == b;
`endif
   // a 16-bit PC has no room for upper PC bits, so the jump field is truncated
   if (WIDTH >= 32) begin : g_j32
      assign jump_pc = {pc[WIDTH-1:28], ir[25:0], 2'b00};
   end else begin : g_j16
      assign jump_pc = {ir[WIDTH-3:0], 2'b00};
   end
   assign wb_addr = op == OP_RTYPE ? ir[15:11] : ir[20:16];
   assign wb_data = op == OP_LW ? mdr : alu_out;
   assign rf_we = state == S_WB && !initialize;
   assign unused_bits = ^{instruction_initialize_address[WIDTH-1:IA+2], instruction_initialize_address[1:0]};
   regfile #(.WIDTH(WIDTH)) u_rf (
      .clk(clk),
      .we(rf_we),
      .ra1(ir[25:21]),
      .ra2(ir[20:16]),
      .wa(wb_addr),
      .wd(wb_data),
      .rd1(rd1),
      .rd2(rd2)
   );
   always_ff @(posedge clk) begin
      if (initialize) imem[instruction_initialize_address[IA+1:2]] <= instruction_initialize_data;
      if (state == S_MEM && op == OP_SW && !initialize) dmem[alu_out[DA+1:2]] <= b;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= S_FETCH;
         pc      <= '0;
         ir      <= '0;
         retired <= '0;
         halted  <= 1'b0;
         a       <= '0;
         b       <= '0;
         simm    <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else if (initialize && state != S_HALT)
         state <= S_FETCH;
      else
         case (state)
            S_FETCH: begin
               ir    <= imem[pc[IA+1:2]];
               pc    <= pc + WIDTH'(4);
               state <= S_DECODE;
            end
            S_DECODE: begin
               a     <= rd1;
               b     <= rd2;
               simm  <= WIDTH'($signed(ir[15:0]));
               state <= S_EXEC;
            end
            S_EXEC: begin
               alu_out <= alu_y;
               if (op == OP_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else if (op == OP_LW || op == OP_SW)
                  state <= S_MEM;
               else if (alu_op != ALU_NONE)
                  state <= S_WB;
               else begin
                  state   <= S_FETCH;
                  retired <= retired + 16'd1;
                  if (op == OP_J) pc <= jump_pc;
                  else if (branch) pc <= pc + (simm << 2);
               end
            end
            S_MEM: begin
               mdr <= dmem[alu_out[DA+1:2]];
               if (op == OP_LW) state <= S_WB;
               else begin
                  state   <= S_FETCH;
                  retired <= retired + 16'd1;
               end
            end
            S_WB: begin
               state   <= S_FETCH;
               retired <= retired + 16'd1;
            end
            default: ;
         endcase
   assign pc_out = pc;
   assign state_out = state;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: random and directed programs checked against an ISA-level interpreter
module tb_multicycle_cpu;
   localparam logic [31:0] HALT = 32'hFC00_0000;
   localparam logic [5:0] FNS [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
`ifdef BNE_EN
   localparam bit BNE = 1'b1;
`else
   localparam bit BNE = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, initialize;
   logic [31:0] init_data, init_addr, pc_out;
   logic [2:0] state_out;
   logic halted;
   logic [15:0] retired;
   int n_checks = 0, n_pass = 0, cyc = 0, mcyc, mret;
   logic [31:0] mpc;
   logic [31:0] mreg [32];
   logic [31:0] mmem [64];
   logic [31:0] prog [$];

   multicycle_cpu dut (
      .clk(clk),
      .rst(rst),
      .initialize(initialize),
      .instruction_initialize_data(init_data),
      .instruction_initialize_address(init_addr),
      .pc_out(pc_out),
      .state_out(state_out),
      .halted(halted),
      .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] enc_j(input int idx);
      return {6'h02, 26'(idx)};
   endfunction

   task automatic load_prog();
      @(negedge clk);
      initialize = 1'b1;
      for (int i = 0; i < 64; i++) begin
         init_addr = 32'(i * 4);
         init_data = i < prog.size() ? prog[i] : HALT;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      initialize = 1'b0;
      cyc = 0;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_halt();
      while (!halted && cyc < 3000) step(1);
      check("halt_reached", 32'(halted), 32'd1);
   endtask

   // Sequential ISA interpreter: one instruction per iteration, cycle cost from the instruction class
   task automatic model_run();
      logic [31:0] pc, npc, w, sim, x, y, ea;
      logic [5:0] op, fn;
      bit done;
      pc = 0;
      mcyc = 0;
      mret = 0;
      done = 0;
      for (int k = 0; k < 500 && !done; k++) begin
         w = pc[7:2] < prog.size() ? prog[pc[7:2]] : HALT;
         op = w[31:26];
         fn = w[5:0];
         sim = {{16{w[15]}}, w[15:0]};
         x = mreg[w[25:21]];
         y = mreg[w[20:16]];
         ea = x + sim;
         npc = pc + 4;
         if (op == 6'h3F) begin
            mcyc += 3;
            done = 1;
         end else begin
            mret++;
            if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
               mcyc += 4;
               if (w[15:11] != 0)
                  mreg[w[15:11]] = fn == 6'h20 ? x + y : fn == 6'h22 ? x - y : fn == 6'h24 ? x & y :
                                   fn == 6'h25 ? x | y : {31'd0, $signed(x) < $signed(y)};
            end else if (op == 6'h08) begin
               mcyc += 4;
               if (w[20:16] != 0) mreg[w[20:16]] = ea;
            end else if (op == 6'h23) begin
               mcyc += 5;
               if (w[20:16] != 0) mreg[w[20:16]] = mmem[ea[7:2]];
            end else if (op == 6'h2B) begin
               mcyc += 4;
               mmem[ea[7:2]] = y;
            end else begin
               mcyc += 3;
               if ((op == 6'h04 && x == y) || (BNE && op == 6'h05 && x != y)) npc = npc + sim * 4;
               else if (op == 6'h02) npc = {npc[31:28], w[25:0], 2'b00};
            end
         end
         pc = npc;
      end
      mpc = pc;
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_cycles"}, 32'(cyc), 32'(mcyc));
      check({tag, "_retired"}, {16'd0, retired}, {16'd0, mret[15:0]});
      check({tag, "_pc"}, pc_out, mpc);
      check({tag, "_state"}, 32'(state_out), 32'd5);
      for (int i = 1; i < 32; i++) check($sformatf("%s_r%0d", tag, i), dut.u_rf.regs[i], mreg[i]);
      for (int i = 0; i < 16; i++) check($sformatf("%s_m%0d", tag, i), dut.dmem[i], mmem[i]);
   endtask

   task automatic exec_prog(input string tag);
      load_prog();
      run_halt();
      model_run();
      compare_all(tag);
   endtask

   task automatic gen_random(input int n);
      logic [4:0] rs, rt, rd;
      prog.delete();
      for (int i = 0; i < n; i++) begin
         rs = 5'($urandom);
         rt = 5'($urandom);
         rd = 5'($urandom);
         if ($urandom_range(0, 2) == 0) rt = rs;
         case ($urandom_range(0, 8))
            0: prog.push_back(enc_i(6'h08, rs, rt, 16'($urandom)));
            1: prog.push_back(enc_r(rs, rt, rd, FNS[$urandom_range(0, 4)]));
            2: prog.push_back(enc_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 15) * 4)));
            3: prog.push_back(enc_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 15) * 4)));
            4: prog.push_back(enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3))));
            5: prog.push_back(enc_i(6'h05, rs, rt, 16'($urandom_range(0, 3))));
            6: prog.push_back(enc_j(i + 1 + $urandom_range(0, 3)));
            7: prog.push_back({6'h3E, 26'($urandom)});
            default: prog.push_back(enc_r(rs, rt, rd, 6'h00));
         endcase
      end
   endtask

   initial begin
      logic [15:0] imm;
      rst = 1'b1;
      initialize = 1'b0;
      init_data = '0;
      init_addr = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      for (int i = 0; i < 64; i++) mmem[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_pc", pc_out, 32'd0);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_retired", {16'd0, retired}, 32'd0);
      rst = 1'b0;

      prog.delete();
      for (int r = 1; r < 32; r++) prog.push_back(enc_i(6'h08, 5'd0, 5'(r), 16'($urandom)));
      for (int k = 0; k < 16; k++) prog.push_back(enc_i(6'h2B, 5'd0, 5'(k + 1), 16'(k * 4)));
      exec_prog("init");

      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd7), enc_r(5'd1, 5'd2, 5'd3, 6'h20), HALT};
      exec_prog("add3");
      check("add3_r3", dut.u_rf.regs[3], 32'd12);
      check("add3_cyc15", 32'(cyc), 32'd15);
      check("add3_ret3", {16'd0, retired}, 32'd3);

      prog = '{enc_i(6'h2B, 5'd0, 5'd3, 16'd8), enc_i(6'h23, 5'd0, 5'd4, 16'd8), HALT};
      load_prog();
      step(4);
      check("sw4_state", 32'(state_out), 32'd0);
      check("sw4_pc", pc_out, 32'd4);
      step(5);
      check("lw5_state", 32'(state_out), 32'd0);
      check("lw5_pc", pc_out, 32'd8);
      run_halt();
      model_run();
      compare_all("swlw");
      check("swlw_r4", dut.u_rf.regs[4], 32'd12);

      prog = '{enc_i(6'h08, 5'd0, 5'd0, 16'd9), enc_r(5'd0, 5'd0, 5'd5, 6'h20), HALT};
      exec_prog("r0");
      check("r0_r5", dut.u_rf.regs[5], 32'd0);

      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd3), enc_i(6'h08, 5'd0, 5'd2, 16'd4), enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF), HALT};
      exec_prog("beq_nt");
      check("beq_nt_cyc", 32'(cyc), 32'd14);

      prog = '{enc_r(5'd0, 5'd0, 5'd7, 6'h20), enc_i(6'h08, 5'd0, 5'd1, 16'd1), enc_i(6'h08, 5'd0, 5'd2, 16'd2),
               enc_i(6'h05, 5'd1, 5'd2, 16'd2), enc_i(6'h08, 5'd0, 5'd7, 16'd1), enc_i(6'h08, 5'd0, 5'd7, 16'd2), HALT};
      exec_prog("bne");
      check("bne_r7", dut.u_rf.regs[7], BNE ? 32'd0 : 32'd2);

      for (int t = 0; t < 10; t++) begin
         gen_random(20);
         exec_prog($sformatf("rnd%0d", t));
      end

      prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd3), enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF)};
      load_prog();
      step(4);
      check("loop_pc_a", pc_out, 32'd4);
      step(3);
      check("loop_pc_b", pc_out, 32'd4);
      check("loop_state_b", 32'(state_out), 32'd0);
      step(3);
      check("loop_pc_c", pc_out, 32'd4);
      check("loop_ret", {16'd0, retired}, 32'd3);
      mreg[1] = 32'd3;

      imm = ~mmem[1][15:0];
      prog = '{enc_i(6'h08, 5'd0, 5'd6, imm), enc_i(6'h2B, 5'd0, 5'd6, 16'd4), HALT};
      load_prog();
      step(7);
      check("mem_state", 32'(state_out), 32'd3);
      rst = 1'b1;
      #1;
      check("abort_pc", pc_out, 32'd0);
      check("abort_state", 32'(state_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mreg[6] = {{16{imm[15]}}, imm};
      check("abort_mem", dut.dmem[1], mmem[1]);
      check("abort_r6", dut.u_rf.regs[6], mreg[6]);

      prog = '{{6'h3E, 26'd0}, {6'h3E, 26'd0}, {6'h3E, 26'd0}, HALT};
      load_prog();
      force dut.retired = 16'hFFFE;
      #1;
      release dut.retired;
      check("wrap_pre", {16'd0, retired}, 32'h0000_FFFE);
      step(6);
      check("wrap_zero", {16'd0, retired}, 32'd0);
      run_halt();
      check("wrap_end", {16'd0, retired}, 32'd1);

      @(negedge clk);
      initialize = 1'b1;
      init_addr = 32'd240;
      init_data = 32'h1234_5678;
      @(negedge clk);
      initialize = 1'b0;
      check("halt_imem", dut.imem[60], 32'h1234_5678);
      check("halt_stays", 32'(halted), 32'd1);
      step(3);
      check("halt_state", 32'(state_out), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
